i2c_txn_sequencer: RTL

I2C_TXN_SEQUENCER -- requirements
Module: i2c_txn_sequencer

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_byte_fifo.sv | 61 ++++++
 rtl/i2c_txn_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction sequencer: FSM states and parameter defaults.
package i2c_pkg;

    localparam int unsigned I2C_DEPTH_DEF   = 4;
    localparam int unsigned I2C_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_WAIT,
        ST_STOP,
        ST_DONE
    } seq_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// Byte FIFO with synchronous flush; push while full succeeds only when a pop happens in the same cycle.
module i2c_byte_fifo
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH = I2C_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    input  logic       flush,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !flush)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Sequences FIFO bytes into an I2C master: start, per-byte handshake with timeout, stop, completion pulse.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned DEPTH   = I2C_DEPTH_DEF,
    parameter int unsigned TIMEOUT = I2C_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    input  logic       go,
    output logic       busy,
    output logic       m_start,
    output logic       m_stop,
    output logic [7:0] m_din,
    output logic       m_chk,
    input  logic       m_done,
    input  logic       m_ack,
    output logic       txn_done,
    output logic       nack_err,
    output logic       tmo_err,
    output logic [7:0] byte_cnt
);

    localparam int unsigned          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT - 1);

    seq_state_e    r_state;
    logic          r_busy, r_start, r_stop, r_chk, r_txn_done, r_nack, r_tmo;
    logic [7:0]    r_din;
    logic [7:0]    r_byte_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic          w_empty, w_pop, w_flush, w_tmo_hit;
    logic [7:0]    w_head;

    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    assign w_pop     = (r_state == ST_SEND);
    // Both abort paths drain the FIFO in the same cycle the WAIT decision is taken.
    assign w_flush   = (r_state == ST_WAIT) && (m_done ? !m_ack : w_tmo_hit);

    i2c_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (w_pop),
        .flush (w_flush),
        .full  (full),
        .empty (w_empty),
        .head  (w_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_chk      <= 1'b0;
            r_txn_done <= 1'b0;
            r_nack     <= 1'b0;
            r_tmo      <= 1'b0;
            r_din      <= '0;
            r_byte_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_chk      <= 1'b0;
            r_txn_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go && !w_empty) begin
                        r_state    <= ST_START;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_nack     <= 1'b0;
                        r_tmo      <= 1'b0;
                        r_byte_cnt <= '0;
                    end
                end
                ST_START: r_state <= ST_SEND;
                ST_SEND: begin
                    r_din     <= w_head;
                    r_chk     <= 1'b1;
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_done) begin
                        if (m_ack) begin
                            r_byte_cnt <= sat_inc8(r_byte_cnt);
                            r_state    <= w_empty ? ST_STOP : ST_SEND;
                            r_stop     <= w_empty;
                        end else begin
                            r_nack  <= 1'b1;
                            r_state <= ST_STOP;
                            r_stop  <= 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_tmo   <= 1'b1;
                        r_state <= ST_STOP;
                        r_stop  <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                ST_STOP: begin
                    r_state    <= ST_DONE;
                    r_txn_done <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign m_start  = r_start;
    assign m_stop   = r_stop;
    assign m_din    = r_din;
    assign m_chk    = r_chk;
    assign txn_done = r_txn_done;
    assign nack_err = r_nack;
    assign tmo_err  = r_tmo;
    assign byte_cnt = r_byte_cnt;

endmodule
